// File: rtl/wash_motor_drv_if.sv
// Command/drive bundle between the wash controller and the motor driver.
//   motor    : 2-bit direction command (00 stop, 01 fwd, 10 rev, 11 illegal)
//   hb_*     : H-bridge gate drives, leg A and leg B, high/low side
//   duty     : current soft-start duty, 0..2^PWM_BITS
//   running  : motor energised in either direction
//   fault    : illegal command seen, drive latched off
interface wash_motor_drv_if #(
    parameter int unsigned PWM_BITS = 4
) ();
    logic [1:0]          motor;
    logic                hb_a_hi;
    logic                hb_a_lo;
    logic                hb_b_hi;
    logic                hb_b_lo;
    logic [PWM_BITS:0]   duty;
    logic                running;
    logic                fault;

    // Controller side: issues commands, observes drive status.
    modport master (
        output motor,
        input  hb_a_hi, hb_a_lo, hb_b_hi, hb_b_lo, duty, running, fault
    );

    // Driver side: consumes commands, produces gate drives and status.
    modport slave (
        input  motor,
        output hb_a_hi, hb_a_lo, hb_b_hi, hb_b_lo, duty, running, fault
    );
endinterface

// File: rtl/wash_motor_drv.sv
// H-bridge motor driver: turns the registered direction command into gate
// drives with dead time on every direction change and a soft-start duty ramp.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : wash_motor_drv_if.slave (motor in; gates, duty, running, fault out)
// All outputs are registered and decoded from the next state, so a command
// change on motor reaches the gates two edges later.
module wash_motor_drv #(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DEAD     = 8,
    parameter int unsigned RAMP_DIV = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    wash_motor_drv_if.slave         bus
);

    localparam int unsigned DUTY_W   = PWM_BITS + 1;
    localparam int unsigned DUTY_MAX = 2 ** PWM_BITS;
    localparam int unsigned DEAD_W   = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam int unsigned RAMP_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [1:0]        CMD_STOP  = 2'b00;
    localparam logic [1:0]        CMD_REV   = 2'b10;
    localparam logic [1:0]        CMD_ILL   = 2'b11;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAD    = 3'd1,
        S_RUN_FWD = 3'd2,
        S_RUN_REV = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    // Registered state
    state_t                 r_state;
    logic [1:0]             r_cmd_q;
    logic                   r_dir_rev;
    logic [DEAD_W-1:0]      r_dead_cnt;
    logic [PWM_BITS-1:0]    r_pwm_cnt;
    logic [RAMP_W-1:0]      r_ramp_cnt;
    logic [DUTY_W-1:0]      r_duty;
    logic                   r_hb_a_hi;
    logic                   r_hb_a_lo;
    logic                   r_hb_b_hi;
    logic                   r_hb_b_lo;
    logic                   r_running;
    logic                   r_fault;

    // Next-state values
    state_t                 w_state_nxt;
    logic                   w_dir_rev_nxt;
    logic [DEAD_W-1:0]      w_dead_cnt_nxt;
    logic [PWM_BITS-1:0]    w_pwm_nxt;
    logic [RAMP_W-1:0]      w_ramp_nxt;
    logic [DUTY_W-1:0]      w_duty_nxt;
    logic                   w_hb_a_hi_nxt;
    logic                   w_hb_a_lo_nxt;
    logic                   w_hb_b_hi_nxt;
    logic                   w_hb_b_lo_nxt;
    logic                   w_running_nxt;
    logic                   w_fault_nxt;
    logic                   w_cmd_rev;
    logic                   w_pwm_on;

    // State, command and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd_q    <= '0;
            r_dir_rev  <= 1'b0;
            r_dead_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_ramp_cnt <= '0;
            r_duty     <= '0;
            r_hb_a_hi  <= 1'b0;
            r_hb_a_lo  <= 1'b0;
            r_hb_b_hi  <= 1'b0;
            r_hb_b_lo  <= 1'b0;
            r_running  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_q    <= bus.motor;
            r_dir_rev  <= w_dir_rev_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
            r_pwm_cnt  <= w_pwm_nxt;
            r_ramp_cnt <= w_ramp_nxt;
            r_duty     <= w_duty_nxt;
            r_hb_a_hi  <= w_hb_a_hi_nxt;
            r_hb_a_lo  <= w_hb_a_lo_nxt;
            r_hb_b_hi  <= w_hb_b_hi_nxt;
            r_hb_b_lo  <= w_hb_b_lo_nxt;
            r_running  <= w_running_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Next-state, counters and output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_dir_rev_nxt  = r_dir_rev;
        w_dead_cnt_nxt = r_dead_cnt;
        w_pwm_nxt      = '0;
        w_ramp_nxt     = '0;
        w_duty_nxt     = '0;
        w_hb_a_hi_nxt  = 1'b0;
        w_hb_a_lo_nxt  = 1'b0;
        w_hb_b_hi_nxt  = 1'b0;
        w_hb_b_lo_nxt  = 1'b0;
        w_running_nxt  = 1'b0;
        w_fault_nxt    = 1'b0;
        w_cmd_rev      = (r_cmd_q == CMD_REV);
        w_pwm_on       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_cmd_q == CMD_ILL) begin
                    w_state_nxt = S_FAULT;
                end else if (r_cmd_q != CMD_STOP) begin
                    w_state_nxt    = S_DEAD;
                    w_dir_rev_nxt  = w_cmd_rev;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end
            end

            S_DEAD: begin
                if (r_cmd_q == CMD_ILL) begin
                    w_state_nxt = S_FAULT;
                end else if (r_cmd_q == CMD_STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cmd_rev != r_dir_rev) begin
                    // Direction flipped mid dead time: full dead period restarts
                    w_dir_rev_nxt  = w_cmd_rev;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end else if (r_dead_cnt == '0) begin
                    // PWM, ramp and duty enter RUN at zero via the defaults
                    w_state_nxt = r_dir_rev ? S_RUN_REV : S_RUN_FWD;
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt - 1'b1;
                end
            end

            S_RUN_FWD, S_RUN_REV: begin
                if (r_cmd_q == CMD_ILL) begin
                    w_state_nxt = S_FAULT;
                end else if (r_cmd_q == CMD_STOP) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cmd_rev != (r_state == S_RUN_REV)) begin
                    w_state_nxt    = S_DEAD;
                    w_dir_rev_nxt  = w_cmd_rev;
                    w_dead_cnt_nxt = DEAD_LOAD;
                end else begin
                    // Same direction: PWM free-runs, duty ramps and saturates
                    w_pwm_nxt  = r_pwm_cnt + 1'b1;
                    w_duty_nxt = r_duty;
                    if (r_ramp_cnt == RAMP_LAST) begin
                        w_ramp_nxt = '0;
                        if (r_duty != DUTY_TOP) begin
                            w_duty_nxt = r_duty + 1'b1;
                        end
                    end else begin
                        w_ramp_nxt = r_ramp_cnt + 1'b1;
                    end
                end
            end

            S_FAULT: begin
                if (r_cmd_q == CMD_STOP) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Gates follow the next state so they switch on the same edge
        w_pwm_on = (DUTY_W'(w_pwm_nxt) < w_duty_nxt);
        case (w_state_nxt)
            S_RUN_FWD: begin
                w_hb_a_hi_nxt = w_pwm_on;
                w_hb_b_lo_nxt = 1'b1;
                w_running_nxt = 1'b1;
            end
            S_RUN_REV: begin
                w_hb_a_lo_nxt = 1'b1;
                w_hb_b_hi_nxt = w_pwm_on;
                w_running_nxt = 1'b1;
            end
            S_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_fault_nxt = 1'b0;
            end
        endcase
    end

    assign bus.hb_a_hi = r_hb_a_hi;
    assign bus.hb_a_lo = r_hb_a_lo;
    assign bus.hb_b_hi = r_hb_b_hi;
    assign bus.hb_b_lo = r_hb_b_lo;
    assign bus.duty    = r_duty;
    assign bus.running = r_running;
    assign bus.fault   = r_fault;

endmodule

// File: tb/tb_wash_motor_drv.sv
// Scoreboard bench for wash_motor_drv: the stimulus thread queues expected
// outputs for future cycles; the monitor compares them on the falling edge.
module tb_wash_motor_drv;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_err;
    int   phase;

    wash_motor_drv_if #(.PWM_BITS(4)) bus ();

    wash_motor_drv #(
        .PWM_BITS (4),
        .DEAD     (8),
        .RAMP_DIV (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] gates;   // {a_hi, a_lo, b_hi, b_lo}
        int         duty;
        logic       running;
        logic       fault;
        int         ph;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [3:0] got_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic void push(int c, logic [3:0] g, int d, logic run, logic flt);
        exp_t e;
        e.cyc = c; e.gates = g; e.duty = d; e.running = run; e.fault = flt; e.ph = phase;
        sb_q.push_back(e);
    endfunction

    function automatic void push_zero(int a, int b);
        for (int c = a; c <= b; c++) push(c, 4'b0000, 0, 1'b0, 1'b0);
    endfunction

    function automatic void push_fault(int a, int b);
        for (int c = a; c <= b; c++) push(c, 4'b0000, 0, 1'b0, 1'b1);
    endfunction

    // Soft start: duty = k/64 capped at 16; high side on while (k mod 16) < duty
    function automatic void push_run(int t0, int k_from, int k_to, bit rev);
        int  d;
        logic p;
        for (int k = k_from; k <= k_to; k++) begin
            d = k / 64;
            if (d > 16) d = 16;
            p = ((k % 16) < d);
            if (rev) push(t0 + k, {1'b0, 1'b1, p, 1'b0}, d, 1'b1, 1'b0);
            else     push(t0 + k, {p, 1'b0, 1'b0, 1'b1}, d, 1'b1, 1'b0);
        end
    endfunction

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Monitor: invariants every cycle, scoreboard entries when their cycle arrives
    always @(negedge clk) begin
        if (cyc >= 1) begin
            n_checks++;
            if ((bus.hb_a_hi & bus.hb_a_lo) === 1'b1 || (bus.hb_b_hi & bus.hb_b_lo) === 1'b1 ||
                (bus.hb_a_hi & bus.hb_b_hi) === 1'b1) begin
                n_err++;
                $display("FAIL shoot_through cyc=%0d got gates=%b%b%b%b want no leg/high pair",
                         cyc, bus.hb_a_hi, bus.hb_a_lo, bus.hb_b_hi, bus.hb_b_lo);
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            got_g = {bus.hb_a_hi, bus.hb_a_lo, bus.hb_b_hi, bus.hb_b_lo};
            if (mon_e.cyc < cyc) begin
                n_err++;
                $display("FAIL missed ph=%0d want_cyc=%0d at cyc=%0d", mon_e.ph, mon_e.cyc, cyc);
            end else if (got_g !== mon_e.gates || bus.duty !== 5'(mon_e.duty) ||
                         bus.running !== mon_e.running || bus.fault !== mon_e.fault) begin
                n_err++;
                $display("FAIL out ph=%0d cyc=%0d got gates=%b duty=%0d run=%b flt=%b want gates=%b duty=%0d run=%b flt=%b",
                         mon_e.ph, cyc, got_g, bus.duty, bus.running, bus.fault,
                         mon_e.gates, mon_e.duty, mon_e.running, mon_e.fault);
            end
        end
    end

    initial begin
        int e, t, e2, t2, e3, e4, t3, e5, t4, e6, e7, t5, e8, t6, e9, e10, e11;
        n_checks = 0;
        n_err    = 0;

        // Reset held 3 cycles with a forward command present
        phase     = 0;
        rst       = 1'b1;
        bus.motor = 2'b01;
        push_zero(1, 3);
        wait_cyc(3);
        rst = 1'b0;

        // Forward start from IDLE after release, ramp through saturation
        phase = 1;
        e = 3;
        t = e + 10;
        push_zero(e + 1, e + 9);
        push_run(t, 0, 20, 1'b0);
        push_run(t, 60, 70, 1'b0);
        push_run(t, 250, 275, 1'b0);
        push_run(t, 1020, 1095, 1'b0);

        // Reversal at full duty
        phase = 2;
        e2 = t + 1100;
        wait_cyc(e2);
        bus.motor = 2'b10;
        push_run(t, 1101, 1101, 1'b0);
        push_zero(e2 + 2, e2 + 9);
        t2 = e2 + 10;
        push_run(t2, 0, 75, 1'b1);

        // Stop, then forward with reverse three cycles later (retarget in DEAD)
        phase = 3;
        e3 = t2 + 80;
        e4 = e3 + 5;
        wait_cyc(e3);
        bus.motor = 2'b00;
        push_run(t2, 81, 81, 1'b1);
        push_zero(e3 + 2, e4 + 12);
        wait_cyc(e4);
        bus.motor = 2'b01;
        wait_cyc(e4 + 3);
        bus.motor = 2'b10;
        t3 = e4 + 13;
        push_run(t3, 0, 10, 1'b1);

        // Back to forward
        phase = 4;
        e5 = e4 + 30;
        wait_cyc(e5);
        bus.motor = 2'b01;
        push_run(t3, e5 + 1 - t3, e5 + 1 - t3, 1'b1);
        push_zero(e5 + 2, e5 + 9);
        t4 = e5 + 10;
        push_run(t4, 0, 10, 1'b0);

        // Illegal code in RUN_FWD; fault holds on 01/10, clears on 00
        phase = 5;
        e6 = t4 + 15;
        wait_cyc(e6);
        bus.motor = 2'b11;
        push_run(t4, 16, 16, 1'b0);
        push_fault(e6 + 2, e6 + 16);
        push_zero(e6 + 17, e6 + 20);
        wait_cyc(e6 + 5);
        bus.motor = 2'b01;
        wait_cyc(e6 + 8);
        bus.motor = 2'b10;
        wait_cyc(e6 + 15);
        bus.motor = 2'b00;

        // Reset in the middle of RUN_FWD
        phase = 6;
        e7 = e6 + 25;
        wait_cyc(e7);
        bus.motor = 2'b01;
        push_zero(e7 + 1, e7 + 9);
        t5 = e7 + 10;
        push_run(t5, 0, 25, 1'b0);
        e8 = t5 + 25;
        wait_cyc(e8);
        rst = 1'b1;
        push_zero(e8 + 1, e8 + 10);
        t6 = e8 + 11;
        push_run(t6, 0, 11, 1'b0);
        wait_cyc(e8 + 1);
        rst = 1'b0;

        // Stop from RUN, then illegal from IDLE
        phase = 7;
        e9 = t6 + 10;
        wait_cyc(e9);
        bus.motor = 2'b00;
        push_zero(e9 + 2, e9 + 6);
        push_fault(e9 + 7, e9 + 11);
        push_zero(e9 + 12, e9 + 15);
        wait_cyc(e9 + 5);
        bus.motor = 2'b11;
        wait_cyc(e9 + 10);
        bus.motor = 2'b00;

        // Stop during DEAD: must not reach RUN
        phase = 8;
        e10 = e9 + 20;
        wait_cyc(e10);
        bus.motor = 2'b01;
        push_zero(e10 + 1, e10 + 15);
        wait_cyc(e10 + 4);
        bus.motor = 2'b00;

        // Illegal during DEAD
        phase = 9;
        e11 = e10 + 20;
        wait_cyc(e11);
        bus.motor = 2'b01;
        push_zero(e11 + 1, e11 + 5);
        push_fault(e11 + 6, e11 + 9);
        push_zero(e11 + 10, e11 + 13);
        wait_cyc(e11 + 4);
        bus.motor = 2'b11;
        wait_cyc(e11 + 8);
        bus.motor = 2'b00;

        wait_cyc(e11 + 20);
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL unchecked ph=%0d want_cyc=%0d never compared by cyc=%0d", mon_e.ph, mon_e.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
